// File: rtl/malu_sequencer.sv
// malu_sequencer
//   Command-driven controller that walks the matrix ALU over a whole matrix.
//   One command (opcode, rows, columns, operand base addresses) is accepted in
//   IDLE. Then, for each element k in 0..rows*cols-1:
//     READ  : read operand RAM at base_a+k / base_b+k (addresses wrap silently)
//     ISSUE : pulse the MALU with the returned element pair
//     WAIT  : wait for MALU completion and capture {hi, lo}
//     OUT   : offer the result on the res_* stream until it is accepted
//   DONE pulses o_done for one cycle and returns to IDLE.
//   An illegal opcode sets o_err and goes straight to DONE. A zero element
//   count goes straight to DONE without error. Neither case reads memory.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
//   are both high. The offering side holds its payload stable, and keeps valid
//   asserted, until that edge. cmd_valid/cmd_ready and res_valid/res_ready both
//   follow this rule. res_ready may be high before res_valid rises.
//
// Ports
//   i_clk, reset_n                        clock; asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op, cmd_size_1/2, cmd_base_a/b
//                                         command input (cmd_ready only in IDLE)
//   mem_rd_en, mem_addr_a/b, mem_data_a/b operand RAM (data one cycle after
//                                         mem_rd_en)
//   malu_i_ready, malu_op_code, malu_size_1/2, malu_mat_1/2
//                                         MALU issue side
//   malu_o_ready, malu_hi, malu_lo        MALU completion and result
//   res_valid/res_ready, res_data, res_last
//                                         result stream
//   o_busy, o_done, o_err                 status (o_err is sticky until the
//                                         next command is accepted)
//   dbg_state_o                           current FSM state, for observation
//
// Build option: MALU_SEQ_TIMEOUT_EN adds a WAIT watchdog. After TIMEOUT_CYC
//   WAIT cycles without malu_o_ready it sets o_err, abandons the remaining
//   elements and goes to DONE.
module malu_sequencer #(
   parameter int BITNESS = 8,
   parameter int ADDR_W  = 8
`ifdef MALU_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                   i_clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_op,
   input  logic [BITNESS-1:0]     cmd_size_1,
   input  logic [BITNESS-1:0]     cmd_size_2,
   input  logic [ADDR_W-1:0]      cmd_base_a,
   input  logic [ADDR_W-1:0]      cmd_base_b,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_addr_a,
   output logic [ADDR_W-1:0]      mem_addr_b,
   input  logic [BITNESS-1:0]     mem_data_a,
   input  logic [BITNESS-1:0]     mem_data_b,
   output logic                   malu_i_ready,
   output logic [7:0]             malu_op_code,
   output logic [BITNESS-1:0]     malu_size_1,
   output logic [BITNESS-1:0]     malu_size_2,
   output logic [BITNESS-1:0]     malu_mat_1,
   output logic [BITNESS-1:0]     malu_mat_2,
   input  logic                   malu_o_ready,
   input  logic [BITNESS-1:0]     malu_hi,
   input  logic [BITNESS-1:0]     malu_lo,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [2*BITNESS-1:0]   res_data,
   output logic                   res_last,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err,
   output logic [2:0]             dbg_state_o
);

   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_DOT   = 8'h03;
   localparam logic [7:0] OP_CROSS = 8'h04;
   localparam logic [7:0] OP_MULI  = 8'h05;
   localparam logic [7:0] OP_DET   = 8'h06;
   localparam logic [7:0] OP_TRANS = 8'h07;

   localparam int CW = 2 * BITNESS;
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        k_q, k_d;
   logic [CW-1:0]        n_q, n_d;
   logic [7:0]           op_q, op_d;
   logic [BITNESS-1:0]   size1_q, size1_d;
   logic [BITNESS-1:0]   size2_q, size2_d;
   logic [ADDR_W-1:0]    base_a_q, base_a_d;
   logic [ADDR_W-1:0]    base_b_q, base_b_d;
   logic [CW-1:0]        res_q, res_d;
   logic                 err_q, err_d;
   logic                 op_legal;
   logic                 last_elem;
   logic [CW-1:0]        size_prod;

`ifdef MALU_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   // Value the counter holds in the final permitted WAIT cycle.
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] timer_q, timer_d;
`endif

   always_comb begin
      op_legal = 1'b0;
      case (cmd_op)
         OP_ADD, OP_SUB, OP_DOT, OP_CROSS, OP_MULI, OP_DET, OP_TRANS: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   // Element count is computed at full double width so 255x255 does not wrap.
   assign size_prod = {{BITNESS{1'b0}}, cmd_size_1} * {{BITNESS{1'b0}}, cmd_size_2};
   assign last_elem = (k_q == n_q - ONE);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      n_d      = n_q;
      op_d     = op_q;
      size1_d  = size1_q;
      size2_d  = size2_q;
      base_a_d = base_a_q;
      base_b_d = base_b_q;
      res_d    = res_q;
      err_d    = err_q;
`ifdef MALU_SEQ_TIMEOUT_EN
      timer_d  = timer_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d     = cmd_op;
               size1_d  = cmd_size_1;
               size2_d  = cmd_size_2;
               base_a_d = cmd_base_a;
               base_b_d = cmd_base_b;
               n_d      = size_prod;
               k_d      = '0;
               err_d    = !op_legal;
               if (!op_legal || size_prod == '0) state_d = S_DONE;
               else                              state_d = S_READ;
            end
         end
         S_READ:  state_d = S_ISSUE;
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef MALU_SEQ_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         S_WAIT: begin
            if (malu_o_ready) begin
               res_d   = {malu_hi, malu_lo};
               state_d = S_OUT;
            end
`ifdef MALU_SEQ_TIMEOUT_EN
            else if (timer_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         S_OUT: begin
            if (res_ready) begin
               if (last_elem) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + ONE;
                  state_d = S_READ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         n_q      <= '0;
         op_q     <= '0;
         size1_q  <= '0;
         size2_q  <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
`ifdef MALU_SEQ_TIMEOUT_EN
         timer_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         n_q      <= n_d;
         op_q     <= op_d;
         size1_q  <= size1_d;
         size2_q  <= size2_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         res_q    <= res_d;
         err_q    <= err_d;
`ifdef MALU_SEQ_TIMEOUT_EN
         timer_q  <= timer_d;
`endif
      end
   end

   assign cmd_ready    = (state_q == S_IDLE);
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = (state_q == S_DONE);
   assign o_err        = err_q;
   assign mem_rd_en    = (state_q == S_READ);
   // The low bits of k are added modulo 2^ADDR_W, so addresses wrap silently.
   assign mem_addr_a   = base_a_q + k_q[ADDR_W-1:0];
   assign mem_addr_b   = base_b_q + k_q[ADDR_W-1:0];
   assign malu_i_ready = (state_q == S_ISSUE);
   // RAM data is forwarded only during the issue pulse; elsewhere it reads 0.
   assign malu_mat_1   = malu_i_ready ? mem_data_a : '0;
   assign malu_mat_2   = malu_i_ready ? mem_data_b : '0;
   assign malu_op_code = op_q;
   assign malu_size_1  = size1_q;
   assign malu_size_2  = size2_q;
   assign res_valid    = (state_q == S_OUT);
   assign res_last     = res_valid && last_elem;
   assign res_data     = res_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_malu_sequencer.sv
// Directed bench for malu_sequencer. Simple RAM and MALU responder models
// provide the data, and a result monitor pops an expected queue.
module tb_malu_sequencer;

   logic        i_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_op = '0;
   logic [7:0]  cmd_size_1 = '0;
   logic [7:0]  cmd_size_2 = '0;
   logic [7:0]  cmd_base_a = '0;
   logic [7:0]  cmd_base_b = '0;
   logic        mem_rd_en;
   logic [7:0]  mem_addr_a, mem_addr_b;
   logic [7:0]  mem_data_a = '0;
   logic [7:0]  mem_data_b = '0;
   logic        malu_i_ready;
   logic [7:0]  malu_op_code, malu_size_1, malu_size_2, malu_mat_1, malu_mat_2;
   logic        malu_o_ready = 1'b0;
   logic [7:0]  malu_hi = '0;
   logic [7:0]  malu_lo = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] res_data;
   logic        res_last;
   logic        o_busy, o_done, o_err;
   logic [2:0]  dbg_state_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  addr_log[$];
   int          rd_count = 0;
   int          hs_count = 0;
   logic        malu_hold = 1'b0;
   int          stall_at = -1;
   int          stall_left = 0;
   logic [23:0] cur_cfg = '0;
   logic        held_v = 1'b0;
   logic [15:0] held_d = '0;

   malu_sequencer dut (
      .i_clk(i_clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_size_1(cmd_size_1), .cmd_size_2(cmd_size_2),
      .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
      .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
      .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
      .malu_i_ready(malu_i_ready), .malu_op_code(malu_op_code),
      .malu_size_1(malu_size_1), .malu_size_2(malu_size_2),
      .malu_mat_1(malu_mat_1), .malu_mat_2(malu_mat_2),
      .malu_o_ready(malu_o_ready), .malu_hi(malu_hi), .malu_lo(malu_lo),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   // ---------------- environment models ----------------
   function automatic logic [7:0] ram_a(input logic [7:0] addr);
      return addr ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_b(input logic [7:0] addr);
      return addr + 8'h11;
   endfunction

   function automatic logic [15:0] exp_res(input logic [7:0] aa, input logic [7:0] bb);
      logic [7:0] a, b;
      a = ram_a(aa);
      b = ram_b(bb);
      return {a + b, a ^ b};
   endfunction

   always @(posedge i_clk) begin
      if (mem_rd_en) begin
         mem_data_a <= ram_a(mem_addr_a);
         mem_data_b <= ram_b(mem_addr_b);
      end
   end

   always @(posedge i_clk) begin
      malu_o_ready <= malu_i_ready && !malu_hold;
      if (malu_i_ready) begin
         malu_hi <= malu_mat_1 + malu_mat_2;
         malu_lo <= malu_mat_1 ^ malu_mat_2;
      end
   end

   // res_ready driver: drops ready for stall_left cycles on result index stall_at
   always begin
      @(posedge i_clk);
      #1;
      if (res_valid && hs_count == stall_at && stall_left > 0) begin
         res_ready = 1'b0;
         stall_left--;
      end else begin
         res_ready = 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      logic [15:0] e;
      forever begin
         @(negedge i_clk);
         if (!reset_n) begin
            held_v = 1'b0;
         end else begin
            if (mem_rd_en) begin
               rd_count++;
               addr_log.push_back(mem_addr_a);
            end
            if (malu_i_ready)
               check("issue_cfg", {malu_op_code, malu_size_1, malu_size_2}, cur_cfg);
            if (held_v)
               check("bp_hold", {res_valid, res_data}, {1'b1, held_d});
            held_v = res_valid && !res_ready;
            held_d = res_data;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  check("res_extra", res_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("res_data", res_data, e);
                  check("res_last", res_last, exp_q.size() == 0);
               end
               hs_count++;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send_cmd(input string tag, input logic [7:0] op, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] ba, input logic [7:0] bb,
                           input int n_res, input int n_rd, input int exp_lat,
                           input logic exp_err);
      int cyc;
      logic got;
      logic err_at;
      exp_q.delete();
      addr_log.delete();
      rd_count = 0;
      hs_count = 0;
      for (int i = 0; i < n_res; i++)
         exp_q.push_back(exp_res(ba + 8'(i), bb + 8'(i)));
      cur_cfg = {op, s1, s2};
      @(posedge i_clk);
      #1;
      check({tag, "_rdy"}, cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_size_1 = s1;
      cmd_size_2 = s2;
      cmd_base_a = ba;
      cmd_base_b = bb;
      @(posedge i_clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 8'hEE;
      cyc = 0;
      got = 1'b0;
      err_at = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge i_clk);
         cyc++;
         if (o_done) begin
            got = 1'b1;
            err_at = o_err;
         end
      end
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_err"}, err_at, exp_err);
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_rd"}, rd_count, n_rd);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] addrs;
      #3;
      check("por_ctl", {cmd_ready, o_busy, o_done, mem_rd_en, malu_i_ready, res_valid, res_last, o_err},
            8'b1000_0000);
      check("por_cfg", {malu_op_code, malu_size_1, malu_size_2}, 0);
      repeat (2) @(posedge i_clk);
      #1;
      reset_n = 1'b1;

      // add, 2x2, no backpressure: 4 results, o_done 17 cycles after accept
      send_cmd("add22", 8'h01, 8'd2, 8'd2, 8'h10, 8'h20, 4, 4, 17, 1'b0);

      // muli, 1x3, result #2 held off for 5 cycles
      stall_at = 1;
      stall_left = 5;
      send_cmd("muli13", 8'h05, 8'd1, 8'd3, 8'h50, 8'h60, 3, 3, 18, 1'b0);
      check("muli13_stalled", stall_left, 0);
      stall_at = -1;

      // illegal opcode: immediate DONE, sticky error, no reads
      send_cmd("ill", 8'h3F, 8'd2, 8'd2, 8'h00, 8'h00, 0, 0, 1, 1'b1);
      @(negedge i_clk);
      check("ill_sticky", {cmd_ready, o_err}, 2'b11);

      // zero rows: DONE without error, error cleared by the accept
      send_cmd("zero", 8'h03, 8'd0, 8'd5, 8'h00, 8'h00, 0, 0, 1, 1'b0);

      // address wrap: FE, FF, 00, 01
      send_cmd("wrap", 8'h07, 8'd1, 8'd4, 8'hFE, 8'h80, 4, 4, 17, 1'b0);
      addrs = '0;
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         addrs = {addrs[23:0], addr_log[i]};
      check("wrap_addr", addrs, 32'hFEFF_0001);

      // reset while waiting on the MALU
      malu_hold = 1'b1;
      cur_cfg = {8'h02, 8'd1, 8'd1};
      exp_q.delete();
      @(posedge i_clk);
      #1;
      cmd_valid  = 1'b1;
      cmd_op     = 8'h02;
      cmd_size_1 = 8'd1;
      cmd_size_2 = 8'd1;
      cmd_base_a = 8'h30;
      cmd_base_b = 8'h40;
      @(posedge i_clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_busy", o_busy, 1);
      check("rst_dbg_wait", dbg_state_o, 3);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_ctl", {cmd_ready, o_busy, o_done, mem_rd_en, malu_i_ready, res_valid, res_last, o_err},
            8'b1000_0000);
      check("rst_cfg", {malu_op_code, malu_size_1, malu_size_2}, 0);
      check("rst_data", {dbg_state_o, res_data}, 0);
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_no_done", o_done, 0);
      reset_n = 1'b1;
      malu_hold = 1'b0;
      send_cmd("post", 8'h04, 8'd1, 8'd2, 8'h30, 8'h40, 2, 2, 9, 1'b0);

`ifdef MALU_SEQ_TIMEOUT_EN
      // MALU never answers: error after 255 WAIT cycles, one read only
      malu_hold = 1'b1;
      send_cmd("tmo", 8'h01, 8'd1, 8'd2, 8'h00, 8'h00, 0, 1, 258, 1'b1);
      malu_hold = 1'b0;
`endif

      repeat (3) @(posedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
